rect_span_gen: RTL

Command front end for the draw pipeline. It accepts one filled-rectangle or buffer-swap command at a time from the CPU side and expands it into per-line span records: two 16-bit words per line. It pushes those words into the draw unit's painter queue using the queue's `we`/`data`/`full` handshake. It sits directly upstream of the draw unit, replacing direct CPU word writes.

---
 rtl/rect_span_gen.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/rect_span_gen.sv
// rect_span_gen
// -----------------------------------------------------------------------------
// Purpose:
//   Command front end for the draw pipeline. It accepts one filled-rectangle or
//   buffer-swap command at a time and expands it into per-line span records.
//   Each record is two 16-bit words, pushed into the draw unit's painter queue
//   through a we/data/full handshake.
//
//   Span word0 : {1'b0, line[6:0], left[7:0]}
//   Span word1 : {color[2:0], 5'b0, right[7:0]}
//   Swap word  : 16'h8000
//
// Configuration:
//   RECT_CLIP_EN  When defined, right and bottom are clamped to the screen.
//                 A command whose left or top edge lies off-screen is treated
//                 as degenerate. When undefined, fields pass through unchanged.
//
// Parameters:
//   SCREEN_W    pixels per line (legal x range 0..SCREEN_W-1)
//   SCREEN_H    lines per frame (legal y range 0..SCREEN_H-1)
//
// Ports:
//   clk         system clock (same as the draw unit)
//   reset       synchronous, active-high reset
//   cmd_valid   command presented
//   cmd_ready   block can accept a command (high only in IDLE)
//   cmd_swap    1 = buffer swap; geometry fields are ignored
//   cmd_top     first line, inclusive
//   cmd_bottom  last line, inclusive
//   cmd_left    first pixel of each span
//   cmd_right   last pixel of each span, inclusive
//   cmd_color   fill colour {R,G,B}
//   we          queue write strobe (combinational: emitting state and !full)
//   data        queue word; held stable while stalled on full
//   full        queue cannot accept a word
//   busy        a command is being expanded
//   span_count  running count of span records emitted, wraps at 16 bits
// -----------------------------------------------------------------------------
module rect_span_gen #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_swap,
  input  logic [6:0]  cmd_top,
  input  logic [6:0]  cmd_bottom,
  input  logic [7:0]  cmd_left,
  input  logic [7:0]  cmd_right,
  input  logic [2:0]  cmd_color,
  output logic        we,
  output logic [15:0] data,
  input  logic        full,
  output logic        busy,
  output logic [15:0] span_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPAN0 = 2'd1,
    SPAN1 = 2'd2,
    SWAP  = 2'd3
  } state_t;

  localparam logic [15:0] SWAP_WORD = 16'h8000;

  // The word formats only hold 8-bit columns and 7-bit line numbers.
  if (SCREEN_W < 1 || SCREEN_W > 256 || SCREEN_H < 1 || SCREEN_H > 128) begin : g_bad_geometry
    $error("rect_span_gen: SCREEN_W must be 1..256 and SCREEN_H 1..128");
  end

  state_t      state;
  state_t      state_next;

  logic [6:0]  line_q;
  logic [6:0]  bottom_q;
  logic [7:0]  left_q;
  logic [7:0]  right_q;
  logic [2:0]  color_q;

  logic [7:0]  clip_right;
  logic [6:0]  clip_bottom;
  logic        off_screen;
  logic        degenerate;
  logic        accept;
  logic        last_line;

  // ---------------------------------------------------------------------------
  // Clipping of the incoming command
  // ---------------------------------------------------------------------------
`ifdef RECT_CLIP_EN
  localparam logic [7:0] MAX_X = 8'(SCREEN_W - 1);
  localparam logic [6:0] MAX_Y = 7'(SCREEN_H - 1);

  assign clip_right  = (cmd_right  > MAX_X) ? MAX_X : cmd_right;
  assign clip_bottom = (cmd_bottom > MAX_Y) ? MAX_Y : cmd_bottom;
  assign off_screen  = (cmd_left > MAX_X) || (cmd_top > MAX_Y);
`else
  assign clip_right  = cmd_right;
  assign clip_bottom = cmd_bottom;
  assign off_screen  = 1'b0;
`endif

  assign degenerate = off_screen || (cmd_left > clip_right) || (cmd_top > clip_bottom);
  assign accept     = (state == IDLE) && cmd_valid;
  assign last_line  = (line_q == bottom_q);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples the
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM next state and outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    we         = 1'b0;
    data       = 16'h0000;

    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_swap)         state_next = SWAP;
          else if (!degenerate) state_next = SPAN0;
          // A degenerate rectangle is consumed here without output.
        end
      end
      SPAN0: begin
        data = {1'b0, line_q, left_q};
        we   = !full;
        if (!full) state_next = SPAN1;
      end
      SPAN1: begin
        data = {color_q, 5'b00000, right_q};
        we   = !full;
        if (!full) state_next = last_line ? IDLE : SPAN0;
      end
      SWAP: begin
        data = SWAP_WORD;
        we   = !full;
        if (!full) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command fields, line counter and span counter
  // ---------------------------------------------------------------------------
  // The fields only change in IDLE, so data stays put while stalled on full.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_q     <= '0;
      bottom_q   <= '0;
      left_q     <= '0;
      right_q    <= '0;
      color_q    <= '0;
      span_count <= '0;
    end else begin
      if (accept) begin
        line_q   <= cmd_top;
        bottom_q <= clip_bottom;
        left_q   <= cmd_left;
        right_q  <= clip_right;
        color_q  <= cmd_color;
      end
      if ((state == SPAN1) && we) begin
        span_count <= span_count + 16'd1;
        // The end test stops the counter at the clipped bottom, so it cannot wrap.
        if (!last_line) line_q <= line_q + 7'd1;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign cmd_ready = !busy;

endmodule
